// File: rtl/dpu_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : dpu_sequencer
//  Brief    : Micro-sequencer for the CCU datapath unit. Fetches 16-bit
//             micro-instructions over a req/ack port, issues one DPU op per
//             EXEC cycle, branches on DPU condition codes and handshakes the
//             video-out strobe with a bounded wait.
//  Options  : DPU_SEQ_BRANCH_EN - when defined, op 10 is a conditional
//             branch on cc; otherwise op 10 is a NOP and cc is ignored.
//  Revision : 1.0 - initial release
// ============================================================================
module dpu_sequencer #(
  parameter int PC_W        = 8,
  parameter int START_ADDR  = 0,
  parameter int VID_TIMEOUT = 255
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  output logic            busy,
  output logic            halted,
  output logic            vidErr,
  output logic            imemReq,
  output logic [PC_W-1:0] imemAddr,
  input  logic            imemAck,
  input  logic [15:0]     imemData,
  output logic [3:0]      Abus,
  output logic [3:0]      Bbus,
  output logic [3:0]      Rbus,
  output logic [3:0]      n,
  output logic [7:0]      mData,
  input  logic [3:0]      cc,
  output logic            outEnable,
  input  logic            vidReady
);

  localparam logic [2:0] c_ST_IDLE  = 3'd0;
  localparam logic [2:0] c_ST_FETCH = 3'd1;
  localparam logic [2:0] c_ST_EXEC  = 3'd2;
  localparam logic [2:0] c_ST_VIDEO = 3'd3;
  localparam logic [2:0] c_ST_HALT  = 3'd4;

  localparam logic [3:0] c_OP_LDI  = 4'h8;
  localparam logic [3:0] c_OP_VID  = 4'h9;
  localparam logic [3:0] c_OP_BR   = 4'hA;
  localparam logic [3:0] c_OP_NOP  = 4'hE;
  localparam logic [3:0] c_OP_HALT = 4'hF;

  // Counter only has to reach VID_TIMEOUT-1 (the last allowed VIDEO cycle).
  localparam int               c_CNT_W    = (VID_TIMEOUT < 2) ? 1 : $clog2(VID_TIMEOUT);
  localparam logic [c_CNT_W-1:0] c_VID_LAST = c_CNT_W'(VID_TIMEOUT - 1);
  localparam logic [PC_W-1:0]  c_PC_START = PC_W'(START_ADDR);
  localparam logic [PC_W-1:0]  c_PC_ONE   = PC_W'(1);

  logic [2:0]         r_state;
  logic [2:0]         w_state_nxt;
  logic [PC_W-1:0]    r_pc;
  logic [PC_W-1:0]    w_pc_nxt;
  logic [15:0]        r_instr;
  logic [3:0]         r_n;
  logic [3:0]         r_a;
  logic [3:0]         r_b;
  logic [3:0]         r_r;
  logic [7:0]         r_m;
  logic [c_CNT_W-1:0] r_vcnt;
  logic               r_vid_err;
  logic [3:0]         w_op;
  logic               w_fetch_done;
  logic               w_start_ok;
  logic               w_vid_tmo;
  logic               w_take;

  assign w_op         = r_instr[15:12];
  assign w_fetch_done = (r_state == c_ST_FETCH) && imemAck;
  assign w_start_ok   = start && ((r_state == c_ST_IDLE) || (r_state == c_ST_HALT));
  assign w_vid_tmo    = (r_vcnt == c_VID_LAST);

`ifdef DPU_SEQ_BRANCH_EN
  // Branch when the selected condition bit equals the wanted polarity.
  assign w_take = (w_op == c_OP_BR) && (cc[r_instr[9:8]] == r_instr[10]);
  logic w_unused_bits;
  assign w_unused_bits = r_instr[11];
`else
  assign w_take = 1'b0;
  logic w_unused_bits;
  assign w_unused_bits = ^{cc, r_instr[11:0]};
`endif

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= c_ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Next-state logic.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      c_ST_IDLE:  if (start) w_state_nxt = c_ST_FETCH;
      c_ST_FETCH: if (imemAck) w_state_nxt = c_ST_EXEC;
      c_ST_EXEC: begin
        if (w_op == c_OP_VID)       w_state_nxt = c_ST_VIDEO;
        else if (w_op == c_OP_HALT) w_state_nxt = c_ST_HALT;
        else                        w_state_nxt = c_ST_FETCH;
      end
      c_ST_VIDEO: if (vidReady || w_vid_tmo) w_state_nxt = c_ST_FETCH;
      c_ST_HALT:  if (start) w_state_nxt = c_ST_FETCH;
      default:    w_state_nxt = c_ST_IDLE;
    endcase
  end

  // State-decoded status and handshake outputs.
  always_comb begin
    busy      = 1'b1;
    halted    = 1'b0;
    imemReq   = 1'b0;
    outEnable = 1'b0;
    case (r_state)
      c_ST_IDLE:  busy = 1'b0;
      c_ST_HALT: begin
        busy   = 1'b0;
        halted = 1'b1;
      end
      c_ST_FETCH: imemReq   = 1'b1;
      c_ST_VIDEO: outEnable = 1'b1;
      default:    busy      = 1'b1;
    endcase
  end

  // Program counter update: restart, branch, hold on halt, else increment.
  always_comb begin
    w_pc_nxt = r_pc;
    if (w_start_ok) begin
      w_pc_nxt = c_PC_START;
    end else if (r_state == c_ST_EXEC) begin
      if (w_take)                 w_pc_nxt = PC_W'(r_instr[7:0]);
      else if (w_op != c_OP_HALT) w_pc_nxt = r_pc + c_PC_ONE;
    end
  end

  // Program counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_pc <= c_PC_START;
    else        r_pc <= w_pc_nxt;
  end

  // Latch the instruction on the acknowledged fetch cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)            r_instr <= 16'h0000;
    else if (w_fetch_done) r_instr <= imemData;
  end

  // DPU controls are decoded straight from imemData so they are registered
  // and valid exactly during EXEC; selects and load data hold otherwise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_n <= c_OP_NOP;
      r_a <= 4'h0;
      r_b <= 4'h0;
      r_r <= 4'h0;
      r_m <= 8'h00;
    end else begin
      r_n <= c_OP_NOP;
      if (w_fetch_done) begin
        if (!imemData[15]) begin
          r_n <= imemData[15:12];
          r_r <= imemData[11:8];
          r_a <= imemData[7:4];
          r_b <= imemData[3:0];
        end else if (imemData[15:12] == c_OP_LDI) begin
          r_n <= c_OP_LDI;
          r_r <= imemData[11:8];
          r_m <= imemData[7:0];
        end
      end
    end
  end

  // VIDEO cycle counter and sticky timeout flag (acceptance beats timeout).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vcnt    <= '0;
      r_vid_err <= 1'b0;
    end else begin
      if (r_state == c_ST_VIDEO) r_vcnt <= r_vcnt + c_CNT_W'(1);
      else                       r_vcnt <= '0;
      if (w_start_ok)
        r_vid_err <= 1'b0;
      else if ((r_state == c_ST_VIDEO) && !vidReady && w_vid_tmo)
        r_vid_err <= 1'b1;
    end
  end

  assign imemAddr = r_pc;
  assign n        = r_n;
  assign Abus     = r_a;
  assign Bbus     = r_b;
  assign Rbus     = r_r;
  assign mData    = r_m;
  assign vidErr   = r_vid_err;

endmodule
`default_nettype wire

// File: tb/tb_dpu_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_dpu_sequencer
//  Brief    : Self-checking bench for dpu_sequencer: decode vector table,
//             directed multi-cycle sequences and random programs compared
//             against an instruction-level reference model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_dpu_sequencer;

  localparam int PC_W = 8;
  localparam int VT   = 4;
`ifdef DPU_SEQ_BRANCH_EN
  localparam bit BR_EN = 1'b1;
`else
  localparam bit BR_EN = 1'b0;
`endif

  logic            clk = 1'b0;
  logic            rst_n, start, busy, halted, vidErr, imemReq, imemAck, outEnable, vidReady;
  logic [PC_W-1:0] imemAddr;
  logic [15:0]     imemData;
  logic [3:0]      Abus, Bbus, Rbus, n, cc;
  logic [7:0]      mData;

  always #5 clk = ~clk;

  dpu_sequencer #(.PC_W(PC_W), .START_ADDR(0), .VID_TIMEOUT(VT)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .halted(halted),
    .vidErr(vidErr), .imemReq(imemReq), .imemAddr(imemAddr), .imemAck(imemAck),
    .imemData(imemData), .Abus(Abus), .Bbus(Bbus), .Rbus(Rbus), .n(n),
    .mData(mData), .cc(cc), .outEnable(outEnable), .vidReady(vidReady)
  );

  typedef struct packed {
    logic [7:0] addr;
    logic [3:0] n, r, a, b;
    logic [7:0] m;
  } rec_t;

  typedef struct {
    logic [15:0] instr;
    logic [3:0]  cc;
    logic [3:0]  n, r, a, b;
    logic [7:0]  m;
    int          next;
  } vec_t;

  logic [15:0] imem [256];
  rec_t obs_q[$], exp_q[$];
  int   flen_q[$], ack_dq[$], vid_dq[$], vdur_q[$], exp_vdur[$], plan_q[$];
  int   checks = 0, failures = 0, nop_viol = 0, addr_viol = 0;
  bit   ack_rand = 0;
  bit   exp_err;
  logic [7:0] exp_pc;

  // Memory and video sink responders plus trace monitor, acting on negedges.
  initial begin : resp
    int req_cnt, cur_delay, k, d;
    bit exec_next;
    logic [7:0] fetch_addr;
    req_cnt = 0; cur_delay = 0; k = 0; d = 1; exec_next = 0; fetch_addr = 0;
    imemAck = 0; imemData = 0; vidReady = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        req_cnt = 0; k = 0; exec_next = 0; imemAck = 0; imemData = 0; vidReady = 0;
      end else begin
        if (exec_next) begin
          obs_q.push_back({fetch_addr, n, Rbus, Abus, Bbus, mData});
          exec_next = 0;
        end else if (n != 4'hE) begin
          nop_viol++;
        end
        if (imemReq) begin
          req_cnt++;
          if (req_cnt == 1) begin
            fetch_addr = imemAddr;
            if (ack_dq.size() > 0) cur_delay = ack_dq.pop_front();
            else if (ack_rand)     cur_delay = int'($urandom_range(0, 3));
            else                   cur_delay = 0;
          end else if (imemAddr != fetch_addr) begin
            addr_viol++;
          end
          imemData = imem[imemAddr];
          imemAck  = ((req_cnt - 1) == cur_delay);
          if (imemAck) begin
            flen_q.push_back(req_cnt);
            exec_next = 1;
            req_cnt = 0;
          end
        end else begin
          imemAck = 0; imemData = 0; req_cnt = 0;
        end
        if (outEnable) begin
          k++;
          if (k == 1) begin
            if (vid_dq.size() > 0) d = vid_dq.pop_front();
            else                   d = 1;
          end
          vidReady = (k == d);
        end else begin
          if (k > 0) vdur_q.push_back(k);
          k = 0; vidReady = 0;
        end
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", nm, act, exp);
    end
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst_n = 0; start = 0;
    obs_q.delete(); flen_q.delete(); ack_dq.delete(); vid_dq.delete(); vdur_q.delete();
    for (int i = 0; i < 256; i++) imem[i] = 16'hF000;
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1;
  endtask

  task automatic pulse_start();
    @(posedge clk); #1 start = 1;
    @(posedge clk); #1 start = 0;
  endtask

  task automatic wait_halt(input string nm, input int budget);
    int i;
    i = 0;
    while (!halted && i < budget) begin
      @(posedge clk); #1;
      i++;
    end
    chk({nm, "_halted"}, halted, 1);
  endtask

  // Instruction-level reference: walks the program, one record per issued op.
  task automatic iss_run();
    logic [7:0] pc, hm;
    logic [3:0] hr, ha, hb, op;
    logic [15:0] ins;
    rec_t rc;
    int d;
    pc = 0; hr = 0; ha = 0; hb = 0; hm = 0;
    exp_q.delete(); exp_vdur.delete(); exp_err = 0;
    for (int s = 0; s < 1000; s++) begin
      ins = imem[pc];
      op  = ins[15:12];
      rc.n = 4'hE;
      if (op <= 4'd7) begin
        hr = ins[11:8]; ha = ins[7:4]; hb = ins[3:0]; rc.n = op;
      end else if (op == 4'd8) begin
        hr = ins[11:8]; hm = ins[7:0]; rc.n = 4'd8;
      end
      rc.addr = pc; rc.r = hr; rc.a = ha; rc.b = hb; rc.m = hm;
      exp_q.push_back(rc);
      if (op == 4'hF) break;
      if (op == 4'd9) begin
        d = (plan_q.size() > 0) ? plan_q.pop_front() : 1;
        exp_vdur.push_back((d < VT) ? d : VT);
        if (d > VT) exp_err = 1;
      end
      if (op == 4'hA && BR_EN && (cc[ins[9:8]] == ins[10])) pc = ins[7:0];
      else                                                  pc = pc + 8'd1;
    end
    exp_pc = pc;
  endtask

  vec_t vt[9];

  initial begin : main
    rst_n = 0; start = 0; cc = 0;
    for (int i = 0; i < 256; i++) imem[i] = 16'hF000;

    vt[0] = '{16'h8955, 4'h0, 4'h8, 4'h9, 4'h0, 4'h0, 8'h55, 1};
    vt[1] = '{16'h1A99, 4'h0, 4'h1, 4'hA, 4'h9, 4'h9, 8'h00, 1};
    vt[2] = '{16'h7123, 4'h0, 4'h7, 4'h1, 4'h2, 4'h3, 8'h00, 1};
    vt[3] = '{16'h9000, 4'h0, 4'hE, 4'h0, 4'h0, 4'h0, 8'h00, 1};
    vt[4] = '{16'hC5A5, 4'h0, 4'hE, 4'h0, 4'h0, 4'h0, 8'h00, 1};
    vt[5] = '{16'hF000, 4'h0, 4'hE, 4'h0, 4'h0, 4'h0, 8'h00, -1};
    vt[6] = '{16'hA120, 4'h1, 4'hE, 4'h0, 4'h0, 4'h0, 8'h00, BR_EN ? 32'h20 : 1};
    vt[7] = '{16'hA120, 4'h0, 4'hE, 4'h0, 4'h0, 4'h0, 8'h00, 1};
    vt[8] = '{16'hA230, 4'hB, 4'hE, 4'h0, 4'h0, 4'h0, 8'h00, BR_EN ? 32'h30 : 1};

    // Reset state.
    do_reset();
    chk("rst_busy", busy, 0);        chk("rst_halted", halted, 0);
    chk("rst_vidErr", vidErr, 0);    chk("rst_imemReq", imemReq, 0);
    chk("rst_outEnable", outEnable, 0); chk("rst_n_nop", n, 4'hE);
    chk("rst_imemAddr", imemAddr, 0);
    chk("rst_buses", {Abus, Bbus, Rbus, mData}, 0);

    // Single-instruction decode table.
    for (int i = 0; i < 9; i++) begin
      do_reset();
      imem[0] = vt[i].instr; cc = vt[i].cc;
      pulse_start();
      wait_halt($sformatf("vec%0d", i), 200);
      chk($sformatf("vec%0d_exec", i), (obs_q.size() > 0) ? obs_q[0] : 32'hDEAD,
          {8'h00, vt[i].n, vt[i].r, vt[i].a, vt[i].b, vt[i].m});
      if (vt[i].next >= 0) begin
        chk($sformatf("vec%0d_nfetch", i), obs_q.size(), 2);
        chk($sformatf("vec%0d_next", i), (obs_q.size() > 1) ? obs_q[1].addr : 8'hEE, vt[i].next);
      end else begin
        chk($sformatf("vec%0d_nfetch", i), obs_q.size(), 1);
        chk($sformatf("vec%0d_pc", i), imemAddr, 0);
      end
    end
    cc = 0;

    // Load/ALU/halt program.
    do_reset();
    imem[0] = 16'h8955; imem[1] = 16'h1A99; imem[2] = 16'hF000;
    pulse_start();
    wait_halt("ldalu", 200);
    chk("ldalu_op0", (obs_q.size() > 0) ? obs_q[0] : 0, {8'h00, 4'h8, 4'h9, 4'h0, 4'h0, 8'h55});
    chk("ldalu_op1", (obs_q.size() > 1) ? obs_q[1] : 0, {8'h01, 4'h1, 4'hA, 4'h9, 4'h9, 8'h55});
    chk("ldalu_pc", imemAddr, 2);

    // Fetch stall of 5 cycles.
    do_reset();
    ack_dq.push_back(5);
    pulse_start();
    wait_halt("stall", 200);
    chk("stall_req_cycles", (flen_q.size() > 0) ? flen_q[0] : 0, 6);

    // Video accepted on 3rd cycle, on 4th (same cycle as timeout), and never.
    for (int t = 0; t < 3; t++) begin
      do_reset();
      imem[0] = 16'h9000;
      vid_dq.push_back((t == 0) ? 3 : (t == 1) ? 4 : 99);
      pulse_start();
      wait_halt($sformatf("vid%0d", t), 200);
      chk($sformatf("vid%0d_len", t), (vdur_q.size() > 0) ? vdur_q[0] : 0, (t == 0) ? 3 : 4);
      chk($sformatf("vid%0d_err", t), vidErr, (t == 2) ? 1 : 0);
      chk($sformatf("vid%0d_next", t), (obs_q.size() > 1) ? obs_q[1].addr : 8'hEE, 1);
    end
    // Restart from HALT clears vidErr and reloads pc.
    vid_dq.push_back(1);
    pulse_start();
    chk("restart_vidErr", vidErr, 0);
    chk("restart_pc", imemAddr, 0);
    wait_halt("restart", 200);

    // PC wrap 0xFF -> 0.
    do_reset();
    for (int i = 0; i < 256; i++) imem[i] = 16'hC000;
    pulse_start();
    for (int i = 0; i < 3000 && obs_q.size() < 257; i++) @(posedge clk);
    chk("wrap_nfetch", (obs_q.size() >= 257) ? 1 : 0, 1);
    chk("wrap_ff", (obs_q.size() > 255) ? obs_q[255].addr : 0, 8'hFF);
    chk("wrap_00", (obs_q.size() > 256) ? obs_q[256].addr : 8'hEE, 8'h00);

    // Asynchronous reset in the middle of VIDEO.
    do_reset();
    for (int i = 0; i < 5; i++) imem[i] = 16'hC000;
    imem[5] = 16'h9000;
    vid_dq.push_back(99);
    pulse_start();
    for (int i = 0; i < 200 && !outEnable; i++) begin @(posedge clk); #1; end
    @(posedge clk); #1;
    chk("vrst_pre_oe", outEnable, 1);
    chk("vrst_pre_pc", imemAddr, 6);
    #2 rst_n = 0;
    #1;
    chk("vrst_oe", outEnable, 0);   chk("vrst_busy", busy, 0);
    chk("vrst_pc", imemAddr, 0);    chk("vrst_n", n, 4'hE);

    // Start while busy is ignored.
    do_reset();
    imem[0] = 16'hC000;
    ack_dq.push_back(0); ack_dq.push_back(6);
    pulse_start();
    for (int i = 0; i < 200 && !(imemReq && imemAddr == 1); i++) begin @(posedge clk); #1; end
    pulse_start();
    chk("busy_start_pc", imemAddr, 1);
    chk("busy_start_busy", busy, 1);
    wait_halt("busy_start", 200);
    chk("busy_start_nfetch", obs_q.size(), 2);
    chk("busy_start_final_pc", imemAddr, 1);

    // Random programs against the instruction-level model.
    ack_rand = 1;
    for (int it = 0; it < 20; it++) begin
      int len, tgt;
      logic [3:0] op;
      do_reset();
      len = int'($urandom_range(6, 40));
      for (int i = 0; i < len; i++) begin
        op = 4'($urandom_range(0, 15));
        if (i == len - 1) begin
          imem[i] = 16'hF000;
        end else if (op == 4'hA) begin
          tgt = int'($urandom_range(i + 1, len - 1));
          imem[i] = {4'hA, 1'b0, 1'($urandom), 2'($urandom), 8'(tgt)};
        end else begin
          imem[i] = {op, 12'($urandom)};
        end
      end
      cc = 4'($urandom);
      plan_q.delete();
      for (int i = 0; i < 64; i++) plan_q.push_back(int'($urandom_range(1, 6)));
      vid_dq = plan_q;
      iss_run();
      pulse_start();
      wait_halt($sformatf("rand%0d", it), 3000);
      chk($sformatf("rand%0d_nrec", it), obs_q.size(), exp_q.size());
      for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++)
        chk($sformatf("rand%0d_rec%0d", it, i), obs_q[i], exp_q[i]);
      chk($sformatf("rand%0d_nvid", it), vdur_q.size(), exp_vdur.size());
      for (int i = 0; i < exp_vdur.size() && i < vdur_q.size(); i++)
        chk($sformatf("rand%0d_vid%0d", it, i), vdur_q[i], exp_vdur[i]);
      chk($sformatf("rand%0d_vidErr", it), vidErr, exp_err);
      chk($sformatf("rand%0d_pc", it), imemAddr, exp_pc);
    end

    chk("n_nop_outside_exec", nop_viol, 0);
    chk("imemAddr_stable_in_fetch", addr_viol, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
